// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler
//   Sequences the four enemy tank slots during play. Tanks are admitted one
//   at a time with a minimum gap between grants, drawn for a while before
//   their physics turns on, and held off after destruction before the slot
//   can be reused. In classic mode a finite enemy budget is tracked and a
//   sticky level_clear is raised once it is used up and the field is empty.
//
//   enemy_slot            : one tank slot (EMPTY/APPEAR/ACTIVE/WAIT) with its
//                           own dwell counter.
//   enemy_spawn_scheduler : grant arbitration, gap timer, budget, counters.
//
// Ports (top):
//   clk, rst_n            clock, asynchronous active-low reset
//   enable_game_classic   classic game running (wins if both modes are high)
//   enable_game_infinity  infinity game running
//   kill[3:0]             per-slot one-cycle destroyed pulse
//   enytank_app[3:0]      per-slot appearance enable
//   enytank_phy[3:0]      per-slot physics/fire enable
//   spawn_pulse[3:0]      one-hot pulse on the cycle a slot's tank appears
//   remaining[4:0]        classic: unspawned budget + live; infinity: live
//   kills_total[7:0]      accepted kills this game, saturating
//   level_clear           classic game won, sticky until the game ends

module enemy_slot #(
    parameter int APPEAR_CYC  = 25_000_000,
    parameter int RESPAWN_CYC = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,     // game not running: force EMPTY
    input  logic grant,
    input  logic kill,
    output logic app,
    output logic phy,
    output logic empty,
    output logic live,      // APPEAR or ACTIVE
    output logic kill_acc   // kill taken this cycle
);
    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_APPEAR = 2'd1,
        S_ACTIVE = 2'd2,
        S_WAIT   = 2'd3
    } slot_state_e;

    localparam logic [CNT_W-1:0] APPEAR_LOAD  = CNT_W'(APPEAR_CYC - 1);
    localparam logic [CNT_W-1:0] RESPAWN_LOAD = CNT_W'(RESPAWN_CYC - 1);

    slot_state_e      state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // The counter is loaded with N-1 on entry so each timed state lasts
    // exactly N cycles; the exit happens on the cycle it reads 0.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        if (clear) begin
            state_n = S_EMPTY;
            cnt_n   = '0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (grant) begin
                        state_n = S_APPEAR;
                        cnt_n   = APPEAR_LOAD;
                    end
                end
                S_APPEAR: begin
                    if (cnt_q == '0) state_n = S_ACTIVE;
                    else             cnt_n   = cnt_q - 1'b1;
                end
                S_ACTIVE: begin
                    if (kill) begin
                        state_n = S_WAIT;
                        cnt_n   = RESPAWN_LOAD;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) state_n = S_EMPTY;
                    else             cnt_n   = cnt_q - 1'b1;
                end
                default: state_n = S_EMPTY;
            endcase
        end
    end

    assign app      = (state_q == S_APPEAR) || (state_q == S_ACTIVE);
    assign phy      = (state_q == S_ACTIVE);
    assign empty    = (state_q == S_EMPTY);
    assign live     = app;
    assign kill_acc = phy && kill && !clear;
endmodule

module enemy_spawn_scheduler #(
    parameter int CLASSIC_BUDGET = 20,
    parameter int SPAWN_GAP_CYC  = 50_000_000,
    parameter int APPEAR_CYC     = 25_000_000,
    parameter int RESPAWN_CYC    = 100_000_000,
    parameter int CNT_W          = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_game_classic,
    input  logic       enable_game_infinity,
    input  logic [3:0] kill,
    output logic [3:0] enytank_app,
    output logic [3:0] enytank_phy,
    output logic [3:0] spawn_pulse,
    output logic [4:0] remaining,
    output logic [7:0] kills_total,
    output logic       level_clear
);
    localparam logic [4:0]       BUDGET_INIT = 5'(CLASSIC_BUDGET);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(SPAWN_GAP_CYC - 1);

    logic             game_active;
    logic             active_q;
    logic [4:0]       budget_q;
    logic [CNT_W-1:0] gap_q;
    logic [1:0]       ptr_q;

    logic [3:0] slot_empty, slot_live, slot_kill_acc, grant_vec;
    logic [2:0] live_cnt, kill_cnt;
    logic       sel_found, can_grant;
    logic [1:0] sel, idx;

    assign game_active = enable_game_classic | enable_game_infinity;

    enemy_slot #(
        .APPEAR_CYC (APPEAR_CYC),
        .RESPAWN_CYC(RESPAWN_CYC),
        .CNT_W      (CNT_W)
    ) u_slot [3:0] (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!game_active),
        .grant   (grant_vec),
        .kill    (kill),
        .app     (enytank_app),
        .phy     (enytank_phy),
        .empty   (slot_empty),
        .live    (slot_live),
        .kill_acc(slot_kill_acc)
    );

    always_comb begin
        live_cnt = '0;
        kill_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            live_cnt = live_cnt + {2'b0, slot_live[i]};
            kill_cnt = kill_cnt + {2'b0, slot_kill_acc[i]};
        end
    end

    // Round-robin pick: first EMPTY slot at or after the pointer.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        idx       = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!sel_found && slot_empty[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end
    end

    // Classic rules take precedence when both mode inputs are high, so the
    // budget check only goes away for a pure infinity game.
    assign can_grant = game_active && (gap_q == '0) && sel_found && !level_clear &&
                       (!enable_game_classic || (budget_q != '0));
    assign grant_vec = can_grant ? (4'b0001 << sel) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            budget_q    <= BUDGET_INIT;
            gap_q       <= '0;
            ptr_q       <= '0;
            spawn_pulse <= '0;
            level_clear <= 1'b0;
        end else if (!game_active) begin
            budget_q    <= BUDGET_INIT;
            gap_q       <= '0;
            ptr_q       <= '0;
            spawn_pulse <= '0;
            level_clear <= 1'b0;
        end else begin
            spawn_pulse <= grant_vec;
            if (can_grant) begin
                gap_q <= GAP_LOAD;
                ptr_q <= sel + 2'd1;
                if (enable_game_classic) budget_q <= budget_q - 5'd1;
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
            level_clear <= level_clear ||
                           (enable_game_classic && (budget_q == '0) && (live_cnt == '0));
        end
    end

    // Kill count survives the end of a game for the game-over screen and is
    // only wiped on the first cycle of the next game.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= 1'b0;
            kills_total <= '0;
            remaining   <= '0;
        end else begin
            active_q  <= game_active;
            remaining <= enable_game_classic ? (budget_q + {2'b0, live_cnt})
                                             : {2'b0, live_cnt};
            if (game_active && !active_q)
                kills_total <= '0;
            else if (game_active)
                kills_total <= ({1'b0, kills_total} + {6'b0, kill_cnt} > 9'd255)
                               ? 8'd255 : kills_total + {5'b0, kill_cnt};
        end
    end
endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
module tb_enemy_spawn_scheduler;
    localparam int B = 6;
    localparam int GAP = 10;
    localparam int A = 4;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       classic = 1'b0;
    logic       infinity = 1'b0;
    logic [3:0] kill = 4'b0;
    logic [3:0] app, phy, spawn;
    logic [4:0] remaining;
    logic [7:0] kills_total;
    logic       level_clear;

    int n_checks = 0;
    int n_fail   = 0;

    enemy_spawn_scheduler #(
        .CLASSIC_BUDGET(B), .SPAWN_GAP_CYC(GAP), .APPEAR_CYC(A),
        .RESPAWN_CYC(R), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .enable_game_classic(classic), .enable_game_infinity(infinity),
        .kill(kill), .enytank_app(app), .enytank_phy(phy), .spawn_pulse(spawn),
        .remaining(remaining), .kills_total(kills_total), .level_clear(level_clear)
    );

    always #5 clk = ~clk;

    // Reference model: each slot is described by the cycle it was granted and
    // the cycle it was killed; its state at any cycle follows from elapsed time.
    int   g_t[4];
    int   k_t[4];
    int   mcyc;
    int   m_budget, m_gap_t, m_ptr, m_kills, m_rem, m_grants;
    bit   m_lc, m_prev;
    logic [3:0] m_spawn;

    function automatic int st(int i, int t);
        if (g_t[i] < 0) return 0;
        if (k_t[i] >= 0) return (t < k_t[i] + R) ? 3 : 0;
        return (t < g_t[i] + A) ? 1 : 2;
    endfunction

    function automatic logic [25:0] exp_vec();
        logic [3:0] ea, ep;
        ea = 4'b0;
        ep = 4'b0;
        for (int i = 0; i < 4; i++) begin
            ea[i] = (st(i, mcyc) == 1) || (st(i, mcyc) == 2);
            ep[i] = (st(i, mcyc) == 2);
        end
        return {ea, ep, m_spawn, 5'(m_rem), 8'(m_kills), m_lc};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin g_t[i] = -1; k_t[i] = -1; end
        mcyc = 0; m_budget = B; m_gap_t = 0; m_ptr = 0; m_kills = 0; m_rem = 0;
        m_lc = 0; m_prev = 0; m_spawn = 4'b0;
    endtask

    task automatic tick(input bit cl, input bit inf, input logic [3:0] k);
        int t, live, acc, s;
        bit act, lc_n;
        @(negedge clk);
        classic = cl; infinity = inf; kill = k;
        @(posedge clk);
        t = mcyc;
        act = cl | inf;
        live = 0;
        for (int i = 0; i < 4; i++) if (st(i, t) == 1 || st(i, t) == 2) live++;
        m_rem = (cl ? m_budget : 0) + live;
        if (!act) begin
            for (int i = 0; i < 4; i++) begin g_t[i] = -1; k_t[i] = -1; end
            m_budget = B; m_gap_t = 0; m_ptr = 0; m_spawn = 4'b0; m_lc = 0;
        end else begin
            acc = 0;
            for (int i = 0; i < 4; i++)
                if (k[i] && st(i, t) == 2) begin acc++; k_t[i] = t + 1; end
            lc_n = m_lc || (cl && m_budget == 0 && live == 0);
            s = -1;
            if (t >= m_gap_t && !m_lc && (!cl || m_budget > 0))
                for (int j = 0; j < 4; j++)
                    if (s < 0 && st((m_ptr + j) % 4, t) == 0) s = (m_ptr + j) % 4;
            m_spawn = 4'b0;
            if (s >= 0) begin
                g_t[s] = t + 1; k_t[s] = -1;
                m_spawn[s] = 1'b1;
                m_ptr = (s + 1) % 4;
                m_gap_t = t + GAP;
                if (cl) m_budget--;
                m_grants++;
            end
            m_lc = lc_n;
            if (!m_prev) m_kills = 0;
            else m_kills = (m_kills + acc > 255) ? 255 : m_kills + acc;
        end
        m_prev = act;
        mcyc = t + 1;
        #1;
    endtask

    function automatic logic [25:0] got_vec();
        return {app, phy, spawn, remaining, kills_total, level_clear};
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({app, phy, spawn, remaining, kills_total, level_clear} !== 26'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0", got_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick(0, 0, 4'b0);
        n_checks++;
        if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    // Includes a kill on slot 2 while it is still appearing (cycles 21..24).
    task automatic test_stagger();
        logic [3:0] want;
        for (int c = 1; c <= 40; c++) begin
            tick(1, 0, (c == 23) ? 4'b0100 : 4'b0000);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stagger_c%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            if (c == 1 || c == 11 || c == 21 || c == 31) begin
                want = 4'b0001 << ((c - 1) / 10);
                n_checks++;
                if (spawn !== want) begin
                    n_fail++;
                    $display("FAIL stagger_pulse_c%0d got=%b exp=%b", c, spawn, want);
                end
            end
            if (c == 5) begin
                n_checks++;
                if (phy[0] !== 1'b1 || app[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stagger_phy0 got=%b%b exp=11", app[0], phy[0]);
                end
            end
            if (c == 23) begin
                n_checks++;
                if (app[2] !== 1'b1 || kills_total !== 8'd0) begin
                    n_fail++;
                    $display("FAIL ignored_kill app2=%b kills=%0d exp app2=1 kills=0", app[2], kills_total);
                end
            end
            if (c >= 2) begin
                n_checks++;
                if (remaining !== 5'd6) begin
                    n_fail++;
                    $display("FAIL stagger_remaining_c%0d got=%0d exp=6", c, remaining);
                end
            end
        end
    endtask

    task automatic test_kill_respawn();
        int kc, rc;
        tick(1, 0, 4'b0010);
        kc = mcyc;
        n_checks++;
        if (app[1] !== 1'b0 || phy[1] !== 1'b0 || kills_total !== 8'd1) begin
            n_fail++;
            $display("FAIL kill_drop app1=%b phy1=%b kills=%0d exp 0 0 1", app[1], phy[1], kills_total);
        end
        rc = -1;
        for (int c = 0; c < 30; c++) begin
            tick(1, 0, 4'b0);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL respawn_c%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            if (spawn[1] && rc < 0) rc = mcyc;
        end
        n_checks++;
        if (rc < kc + R) begin
            n_fail++;
            $display("FAIL respawn_delay got=%0d exp>=%0d", rc, kc + R);
        end
        n_checks++;
        if (remaining !== 5'd5) begin
            n_fail++;
            $display("FAIL respawn_remaining got=%0d exp=5", remaining);
        end
    endtask

    task automatic test_exhaustion();
        for (int c = 0; c < 400 && !m_lc; c++) begin
            tick(1, 0, 4'hF);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL exhaust_c%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
        end
        n_checks++;
        if (level_clear !== 1'b1 || remaining !== 5'd0 || kills_total !== 8'd6) begin
            n_fail++;
            $display("FAIL exhaust_done lc=%b rem=%0d kills=%0d exp 1 0 6", level_clear, remaining, kills_total);
        end
        repeat (5) tick(1, 0, 4'b0);
        n_checks++;
        if (spawn !== 4'b0 || app !== 4'b0 || level_clear !== 1'b1) begin
            n_fail++;
            $display("FAIL exhaust_no_grant spawn=%b app=%b lc=%b", spawn, app, level_clear);
        end
        tick(0, 0, 4'b0);
        n_checks++;
        if (level_clear !== 1'b0 || kills_total !== 8'd6) begin
            n_fail++;
            $display("FAIL game_over lc=%b kills=%0d exp 0 6", level_clear, kills_total);
        end
    endtask

    task automatic test_infinity();
        int dut_grants, g0;
        dut_grants = 0;
        g0 = m_grants;
        for (int c = 0; c < 200; c++) begin
            tick(0, 1, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL infinity_c%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            dut_grants += $countones(spawn);
        end
        n_checks++;
        if (dut_grants !== m_grants - g0 || dut_grants <= B) begin
            n_fail++;
            $display("FAIL infinity_grants got=%0d exp=%0d (>%0d)", dut_grants, m_grants - g0, B);
        end
        tick(0, 0, 4'b0);
    endtask

    task automatic test_async_reset();
        tick(1, 0, 4'b0);
        tick(1, 0, 4'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (app !== 4'b0 || phy !== 4'b0 || spawn !== 4'b0 || kills_total !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset app=%b phy=%b spawn=%b", app, phy, spawn);
        end
        classic = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0, 4'b0);
        tick(1, 0, 4'b0);
        n_checks++;
        if (spawn !== 4'b0001 || got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL after_reset_grant got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int mode;
        mode = 0;
        for (int c = 0; c < 600; c++) begin
            if (c % 75 == 0) mode = $urandom_range(0, 3);
            tick(mode[0], mode[1], ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0);
            n_checks++;
            if (got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_c%0d mode=%0d got=%h exp=%h", c, mode, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        m_grants = 0;
        model_reset();
        test_reset();
        test_stagger();
        test_kill_respawn();
        test_exhaustion();
        test_infinity();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
